// File: rtl/barrel_shift_arbiter.sv
`timescale 1ns/1ps
// barrel_shifter8
//   8-bit bidirectional logical barrel shifter with zero fill. Purely
//   combinational, built as three log2 stages (1, 2, 4 positions).
//   data   : operand
//   amt    : shift amount, 0..7
//   dir    : 0 = logical right, 1 = logical left
//   result : shifted operand
module barrel_shifter8 (
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  logic       dir,
  output logic [7:0] result
);

  logic [7:0] stage1;
  logic [7:0] stage2;

  assign stage1 = amt[0] ? (dir ? {data[6:0], 1'b0}   : {1'b0, data[7:1]})   : data;
  assign stage2 = amt[1] ? (dir ? {stage1[5:0], 2'b0} : {2'b0, stage1[7:2]}) : stage1;
  assign result = amt[2] ? (dir ? {stage2[3:0], 4'b0} : {4'b0, stage2[7:4]}) : stage2;

endmodule

// barrel_shift_arbiter
//   Two-requester front end to a single shared barrel shifter. One request
//   is granted at a time (round-robin or fixed priority), its operands are
//   latched, and the operation runs as one pass (SRL, SLL, rotate by 0) or
//   two passes (rotate by 1..7, built as a shift one way OR'd with the
//   complementary shift the other way). The result is held until consumed.
//
//   Parameter FIXED_PRIORITY : 0 = round-robin, 1 = port 0 always wins
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  : request handshake for port N (N = 0, 1)
//   reqN_data                : 8-bit operand
//   reqN_shamt               : shift/rotate amount, 0..7
//   reqN_op                  : 00 SRL, 01 SLL, 10 ROR, 11 ROL
//   res_valid / res_ready    : result handshake
//   res_data                 : 8-bit result
//   res_id                   : index of the requester that owns the result
module barrel_shift_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic [2:0] req0_shamt,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic [2:0] req1_shamt,
  input  logic [1:0] req1_op,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_id
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] data_q;
  logic [2:0] shamt_q;
  logic [1:0] op_q;
  logic [7:0] temp;
  logic       favour1;     // round-robin pointer: 1 = port 1 wins a tie
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       two_pass;
  logic [2:0] sh_amt;
  logic       sh_dir;
  logic [7:0] sh_out;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIORITY != 0 || !favour1) grant0 = 1'b1;
      else                                 grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign req0_ready = (state == IDLE) && !rst && grant0;
  assign req1_ready = (state == IDLE) && !rst && grant1;
  assign accept     = req0_ready || req1_ready;
  assign res_valid  = (state == DONE);

  // Rotates by a non-zero amount need the complementary shift in PASS2.
  assign two_pass = op_q[1] && (shamt_q != 3'd0);

  // op[0] is the direction of the first pass for both shifts and rotates;
  // PASS2 shifts the other way by 8 - shamt.
  assign sh_amt = (state == PASS2) ? 3'(4'd8 - {1'b0, shamt_q}) : shamt_q;
  assign sh_dir = (state == PASS2) ? !op_q[0] : op_q[0];

  barrel_shifter8 u_shifter (
    .data   (data_q),
    .amt    (sh_amt),
    .dir    (sh_dir),
    .result (sh_out)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = PASS1;
      PASS1: next_state = two_pass ? PASS2 : DONE;
      PASS2: next_state = DONE;
      DONE:  if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: all datapath registers are reset, including the operand latches;
  // there is no memory array here, so nothing is left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      shamt_q  <= '0;
      op_q     <= '0;
      temp     <= '0;
      res_data <= '0;
      res_id   <= 1'b0;
      favour1  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          data_q  <= grant1 ? req1_data  : req0_data;
          shamt_q <= grant1 ? req1_shamt : req0_shamt;
          op_q    <= grant1 ? req1_op    : req0_op;
          res_id  <= grant1;
          favour1 <= !grant1;
        end
        PASS1: if (two_pass) temp <= sh_out;
               else          res_data <= sh_out;
        PASS2: res_data <= sh_out | temp;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
`timescale 1ns/1ps
// tb_barrel_shift_arbiter
//   Table-driven single-request vectors, hand-written multi-cycle sequences
//   (alternation, back-pressure, mid-operation reset), and a randomized run
//   against a timeline model of the arbiter.
module tb_barrel_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic [2:0] req0_shamt = '0, req1_shamt = '0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic       res_ready = 1'b1;
  logic       req0_ready, req1_ready, res_valid, res_id;
  logic [7:0] res_data;
  logic       fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id;
  logic [7:0] fp_res_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  barrel_shift_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .res_valid(fp_res_valid), .res_ready(res_ready), .res_data(fp_res_data), .res_id(fp_res_id)
  );

  typedef struct {
    bit         port;
    logic [7:0] data;
    logic [2:0] shamt;
    logic [1:0] op;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: rotates written as arithmetic on a wide integer.
  function automatic logic [7:0] ref_op(input logic [7:0] d, input int s, input logic [1:0] op);
    int v;
    v = d;
    case (op)
      2'b00:   return 8'((v >> s) & 255);
      2'b01:   return 8'((v << s) & 255);
      2'b10:   return 8'(((v >> s) | (v << (8 - s))) & 255);
      default: return 8'(((v << s) | (v >> (8 - s))) & 255);
    endcase
  endfunction

  function automatic int ref_lat(input int s, input logic [1:0] op);
    return (op[1] && s != 0) ? 3 : 2;
  endfunction

  task automatic drive_port(input bit port, input logic [7:0] d, input logic [2:0] s,
                            input logic [1:0] op);
    if (port) begin req1_data = d; req1_shamt = s; req1_op = op; end
    else      begin req0_data = d; req0_shamt = s; req0_op = op; end
  endtask

  // Pulses reset and checks the outputs while it is held with both ports valid.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst req0_ready", req0_ready, 0);
    check("rst req1_ready", req1_ready, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst res_id", res_id, 0);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
  endtask

  // One request on one port; measures cycles from the accept cycle to res_valid.
  task automatic do_op(input string name, input bit port, input logic [7:0] d,
                       input logic [2:0] s, input logic [1:0] op,
                       input logic [7:0] exp, input int exp_lat);
    bit got;
    int lat;
    @(negedge clk);
    res_ready = 1'b1;
    req0_valid = !port; req1_valid = port;
    req0_valid = req0_valid && 1'b0 || !port;
    req1_valid = port;
    if (port) req0_valid = 1'b0;
    drive_port(port, d, s, op);
    #1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (port ? req1_ready : req0_ready) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check({name, " accepted"}, got, 1);
    lat = 0;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      // Operands change after accept; the latched copy must be used.
      drive_port(port, ~d, 3'($urandom), 2'($urandom));
      #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " res_data"}, res_data, exp);
    check({name, " res_id"}, res_id, port);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   busy, favour, g0, g1, p;
    int   k, lat, nacc, nres, fp_acc, last_id;
    logic [7:0] exp_d;

    vecs[0] = '{0, 8'hB5, 3'd3, 2'b01, 8'hA8, 2};
    vecs[1] = '{1, 8'hB5, 3'd3, 2'b00, 8'h16, 2};
    vecs[2] = '{0, 8'hB5, 3'd3, 2'b11, 8'hAD, 3};
    vecs[3] = '{1, 8'h81, 3'd1, 2'b10, 8'hC0, 3};
    vecs[4] = '{0, 8'h3C, 3'd0, 2'b11, 8'h3C, 2};
    vecs[5] = '{1, 8'h80, 3'd7, 2'b00, 8'h01, 2};
    vecs[6] = '{0, 8'hFF, 3'd0, 2'b01, 8'hFF, 2};
    vecs[7] = '{1, 8'h3C, 3'd0, 2'b10, 8'h3C, 2};
    vecs[8] = '{0, 8'h81, 3'd7, 2'b11, 8'hC0, 3};
    vecs[9] = '{1, 8'h12, 3'd4, 2'b10, 8'h21, 3};

    reset_dut();

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].data, vecs[i].shamt,
            vecs[i].op, vecs[i].exp, vecs[i].lat);

    // Both ports valid continuously: round-robin alternates, fixed priority
    // keeps serving port 0.
    reset_dut();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h01; req0_shamt = 3'd1; req0_op = 2'b01;
    req1_valid = 1'b1; req1_data = 8'h80; req1_shamt = 3'd1; req1_op = 2'b00;
    res_ready = 1'b1;
    nacc = 0; nres = 0; fp_acc = 0; last_id = 0;
    for (int c = 0; c < 40 && nres < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        p = req1_ready;
        check($sformatf("alt grant %0d", nacc), p, nacc % 2);
        last_id = p;
        nacc++;
      end
      if (res_valid) begin
        check($sformatf("alt res_id %0d", nres), res_id, last_id);
        check($sformatf("alt res_data %0d", nres), res_data, last_id ? 8'h40 : 8'h02);
        nres++;
      end
      check("fp req1_ready", fp_req1_ready, 0);
      if (fp_req0_ready) fp_acc++;
      if (fp_res_valid) check("fp res_id", fp_res_id, 0);
      @(negedge clk);
    end
    check("alt results", nres, 4);
    check("fp accepts", fp_acc >= 3, 1);

    // Back-pressure: result held for 5 cycles, no accept while in DONE.
    reset_dut();
    @(negedge clk);
    res_ready = 1'b0;
    req0_valid = 1'b1; drive_port(0, 8'hB5, 3'd3, 2'b11);
    #1;
    check("hold accept", req0_ready, 1);
    k = 0;
    do begin @(negedge clk); req0_valid = 1'b0; #1; k++; end while (!res_valid && k < 8);
    check("hold latency", k, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; drive_port(0, 8'h00, 3'd1, 2'b00);
      #1;
      check("hold res_valid", res_valid, 1);
      check("hold res_data", res_data, 8'hAD);
      check("hold req0_ready", req0_ready, 0);
      check("hold req1_ready", req1_ready, 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("consume res_valid", res_valid, 1);
    check("consume req0_ready", req0_ready, 0);
    check("consume req1_ready", req1_ready, 0);
    @(negedge clk);
    #1;
    check("after consume res_valid", res_valid, 0);
    check("after consume req0_ready", req0_ready, 0);
    check("after consume req1_ready", req1_ready, 1);

    // Reset during PASS2 of a rotate discards it and restores port 0 priority.
    reset_dut();
    do_op("pre-rst", 1, 8'h0F, 3'd2, 2'b01, 8'h3C, 2);
    @(negedge clk);
    req1_valid = 1'b0; req0_valid = 1'b1; drive_port(0, 8'h81, 3'd2, 2'b11);
    #1;
    check("rst-seq accept", req0_ready, 1);
    @(negedge clk); req0_valid = 1'b0; #1;
    check("rst-seq pass1 res_valid", res_valid, 0);
    @(negedge clk); #1;
    check("rst-seq pass2 res_valid", res_valid, 0);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("async rst res_data", res_data, 0);
    check("async rst res_id", res_id, 0);
    check("async rst res_valid", res_valid, 0);
    check("async rst req0_ready", req0_ready, 0);
    check("async rst req1_ready", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("post-rst res_valid", res_valid, 0);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post-rst grant0", req0_ready, 1);
    check("post-rst grant1", req1_ready, 0);

    // Randomized traffic against a timeline model.
    reset_dut();
    busy = 1'b0; favour = 1'b0; k = 0; lat = 0; exp_d = '0; last_id = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      drive_port(0, 8'($urandom), 3'($urandom), 2'($urandom));
      drive_port(1, 8'($urandom), 3'($urandom), 2'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!busy) begin
        g0 = req0_valid && (!req1_valid || !favour);
        g1 = req1_valid && (!req0_valid || favour);
        check("rnd req0_ready", req0_ready, g0);
        check("rnd req1_ready", req1_ready, g1);
        check("rnd idle res_valid", res_valid, 0);
        if (g0 || g1) begin
          p       = g1;
          exp_d   = p ? ref_op(req1_data, req1_shamt, req1_op)
                      : ref_op(req0_data, req0_shamt, req0_op);
          lat     = p ? ref_lat(req1_shamt, req1_op) : ref_lat(req0_shamt, req0_op);
          last_id = p;
          favour  = !p;
          busy    = 1'b1;
          k       = 0;
        end
      end else begin
        k++;
        check("rnd busy req0_ready", req0_ready, 0);
        check("rnd busy req1_ready", req1_ready, 0);
        if (k < lat) begin
          check("rnd busy res_valid", res_valid, 0);
        end else begin
          check("rnd res_valid", res_valid, 1);
          check("rnd res_data", res_data, exp_d);
          check("rnd res_id", res_id, last_id);
          if (res_ready) busy = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
